// File: rtl/scan_decoder_n_if.sv
// Select-bus bundle for scan_decoder_n: enable, mode and index in;
// one-cold select, current index and advance tick out.
interface scan_decoder_n_if #(
    parameter int SEL_W = 3
);
    localparam int N = 1 << SEL_W;

    logic             en_i;
    logic             mode_i;
    logic [SEL_W-1:0] data_i;
    logic [N-1:0]     sel_o;
    logic [SEL_W-1:0] idx_o;
    logic             tick_o;

    modport master (
        output en_i, mode_i, data_i,
        input  sel_o, idx_o, tick_o
    );

    modport slave (
        input  en_i, mode_i, data_i,
        output sel_o, idx_o, tick_o
    );
endinterface

// File: rtl/scan_decoder_n.sv
// Registered one-cold decoder with direct and round-robin scan modes.
// Ports: clk_i, rst_n_i (async low), bus (slave: en_i active-low,
// mode_i, data_i -> sel_o active-low, idx_o, tick_o).
// Macro SCAN_BLANK_EN: blank sel_o for the tick cycle of each advance.
module scan_decoder_n #(
    parameter int SEL_W  = 3,
    parameter int NUM_CH = 8,
    parameter int DIV    = 100000
) (
    input logic             clk_i,
    input logic             rst_n_i,
    scan_decoder_n_if.slave bus
);
    localparam int N     = 1 << SEL_W;
    localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_CH - 1);

`ifdef SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    function automatic logic [N-1:0] dec(input logic [SEL_W-1:0] i);
        logic [N-1:0] one;
        one = N'(1);
        return ~(one << i);
    endfunction

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] idxo_q, idxo_d;
    logic [N-1:0]     sel_q, sel_d;
    logic             tick_q, tick_d;
    logic             mode_q;
    // act_q: decoder was enabled last cycle, so a resumed scan
    // gets a full dwell on its held channel.
    logic             act_q;

    logic             entry;
    logic             restart;
    logic             wrap;
    logic [SEL_W-1:0] idx_nx;

    assign entry   = bus.mode_i & ~mode_q;
    assign restart = entry | ~act_q;
    assign wrap    = (pre_q == PRE_LAST);
    assign idx_nx  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    always_comb begin
        pre_d  = pre_q;
        idx_d  = idx_q;
        idxo_d = idxo_q;
        sel_d  = sel_q;
        tick_d = 1'b0;
        if (bus.en_i) begin
            sel_d = '1;
            pre_d = '0;
        end else if (!bus.mode_i) begin
            sel_d  = dec(bus.data_i);
            idxo_d = bus.data_i;
            pre_d  = '0;
        end else if (restart) begin
            pre_d = '0;
            if (entry) begin
                idx_d  = '0;
                idxo_d = '0;
                sel_d  = dec('0);
            end else begin
                idxo_d = idx_q;
                sel_d  = dec(idx_q);
            end
        end else if (wrap) begin
            pre_d  = '0;
            idx_d  = idx_nx;
            idxo_d = idx_nx;
            tick_d = 1'b1;
            sel_d  = BLANK ? '1 : dec(idx_nx);
        end else begin
            pre_d  = pre_q + 1'b1;
            idxo_d = idx_q;
            sel_d  = dec(idx_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre_q  <= '0;
            idx_q  <= '0;
            idxo_q <= '0;
            sel_q  <= '1;
            tick_q <= 1'b0;
            mode_q <= 1'b0;
            act_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            idxo_q <= idxo_d;
            sel_q  <= sel_d;
            tick_q <= tick_d;
            mode_q <= bus.mode_i;
            act_q  <= ~bus.en_i;
        end
    end

    assign bus.sel_o  = sel_q;
    assign bus.idx_o  = idxo_q;
    assign bus.tick_o = tick_q;
endmodule

// File: tb/tb_scan_decoder_n.sv
// Directed scoreboard bench for scan_decoder_n
// (SEL_W=3, NUM_CH=4, DIV=4).
module tb_scan_decoder_n;
    localparam int SEL_W  = 3;
    localparam int NUM_CH = 4;
    localparam int DIV    = 4;

`ifdef SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] sel;
        logic [2:0] idx;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    scan_decoder_n_if #(.SEL_W(SEL_W)) bus ();

    scan_decoder_n #(
        .SEL_W (SEL_W),
        .NUM_CH(NUM_CH),
        .DIV   (DIV)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    function automatic exp_t mk(input int idx, input bit tick, input bit blank);
        exp_t e;
        logic [7:0] one;
        one   = 8'h01;
        e.idx = 3'(idx);
        e.tick = tick;
        e.sel = blank ? 8'hFF : (8'hFF ^ (one << idx));
        return e;
    endfunction

    // Scan position j cycles after a (re)start on channel start.
    function automatic exp_t scan_exp(input int start, input int j);
        int  idx;
        bit  tick;
        idx  = (start + j / DIV) % NUM_CH;
        tick = (j % DIV == 0) && (j > 0);
        return mk(idx, tick, tick && BLANK);
    endfunction

    task automatic chk(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = q.pop_front();
            tests++;
            assert (bus.sel_o === e.sel) else begin
                fails++;
                $error("FAIL %s sel: got %h want %h", tag, bus.sel_o, e.sel);
            end
            tests++;
            assert (bus.idx_o === e.idx) else begin
                fails++;
                $error("FAIL %s idx: got %0d want %0d", tag, bus.idx_o, e.idx);
            end
            tests++;
            assert (bus.tick_o === e.tick) else begin
                fails++;
                $error("FAIL %s tick: got %b want %b", tag, bus.tick_o, e.tick);
            end
        end
    endtask

    task automatic step(input exp_t e, input string tag);
        q.push_back(e);
        @(posedge clk);
        #1;
        chk(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.en_i   = 1'b1;
        bus.mode_i = 1'b0;
        bus.data_i = '0;
        #12;
        q.push_back(mk(0, 0, 1));
        chk("reset");

        rst_n      = 1'b1;
        bus.en_i   = 1'b0;
        bus.data_i = 3'd5;
        step(mk(5, 0, 0), "direct5");

        for (int d = 0; d < 8; d++) begin
            bus.data_i = 3'(d);
            step(mk(d, 0, 0), "sweep");
        end

        bus.data_i = 3'd2;
        step(mk(2, 0, 0), "direct2");
        bus.en_i = 1'b1;
        step(mk(2, 0, 1), "gate_off");
        bus.en_i = 1'b0;
        step(mk(2, 0, 0), "gate_on");

        bus.mode_i = 1'b1;
        bus.data_i = 3'd7;
        for (int j = 0; j < 25; j++) begin
            step(scan_exp(0, j), "scan");
        end

        bus.en_i = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step(mk(2, 0, 1), "scan_off");
        end
        bus.en_i = 1'b0;
        for (int j = 0; j < 7; j++) begin
            step(scan_exp(2, j), "resume");
        end

        #2;
        rst_n = 1'b0;
        q.push_back(mk(0, 0, 1));
        #1;
        chk("async_rst");
        step(mk(0, 0, 1), "rst_hold");
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step(scan_exp(0, j), "post_rst");
        end

        bus.mode_i = 1'b0;
        bus.data_i = 3'd6;
        step(mk(6, 0, 0), "back_direct");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
